// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the CPU control unit and muldiv_unit.
//
// Signals:
//   start    : master -> slave, one-cycle request, only honoured while idle
//   op       : master -> slave, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     : master -> slave, multiplicand/dividend and multiplier/divisor
//   busy     : slave -> master, operation in progress
//   done     : slave -> master, one-cycle completion pulse
//   div_zero : slave -> master, one-cycle pulse with done on divide by zero
//   hi, lo   : slave -> master, result registers
//
// Modports: master (control unit / bench), slave (muldiv_unit).
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative signed/unsigned multiply and divide unit with its own HI/LO
// result registers. One operation is issued with a start pulse; the unit
// works on operand magnitudes and fixes up result signs in a final step.
//
// Parameters:
//   WIDTH : operand/result width in bits (min 4)
//   CNT_W : iteration counter width (derived, do not override)
//
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high; aborts any operation and clears hi/lo
//   bus   : muldiv_unit_if.slave (start/op/a/b in, busy/done/div_zero/hi/lo out)
//
// Build option:
//   MULDIV_EARLY_OUT_EN : when defined, multiply stops as soon as the
//                         remaining multiplier bits are all zero.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Multiplicand (shifted left each MUL step); low half holds the divisor in DIV
    logic [2*WIDTH-1:0] r_mcand;
    // Multiplier (shifted right) in MUL; dividend in, quotient out in DIV
    logic [WIDTH-1:0]   r_shift;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_isDiv;
    logic               r_resNeg;
    logic               r_remNeg;
    logic               r_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_isSigned;
    logic               w_isDiv;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_divByZero;
    logic               w_mulLast;
    logic               w_divLast;
    logic [WIDTH:0]     w_partial;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quotFix;
    logic [WIDTH-1:0]   w_remFix;
    logic               w_busy;
    logic               w_done;
    logic               w_divZero;

    assign w_isSigned  = ~bus.op[0];
    assign w_isDiv     = bus.op[1];
    assign w_aNeg      = w_isSigned & bus.a[WIDTH-1];
    assign w_bNeg      = w_isSigned & bus.b[WIDTH-1];
    // The most negative value maps onto 2^(WIDTH-1), which still fits unsigned
    assign w_absA      = w_aNeg ? -bus.a : bus.a;
    assign w_absB      = w_bNeg ? -bus.b : bus.b;
    assign w_divByZero = w_isDiv && (bus.b == '0);

`ifdef MULDIV_EARLY_OUT_EN
    // Stop once the multiplier bits still to be consumed are all zero
    assign w_mulLast = (r_cnt == CNT_W'(WIDTH - 1)) || (r_shift[WIDTH-1:1] == '0);
`else
    assign w_mulLast = (r_cnt == CNT_W'(WIDTH - 1));
`endif
    assign w_divLast = (r_cnt == CNT_W'(WIDTH - 1));

    // Restoring division: bring the next dividend bit into the partial
    // remainder and subtract the divisor only when it fits
    assign w_partial = {r_rem, r_shift[WIDTH-1]};
    assign w_ge      = (w_partial >= {1'b0, r_mcand[WIDTH-1:0]});

    assign w_prodFix = r_resNeg ? -r_acc   : r_acc;
    assign w_quotFix = r_resNeg ? -r_shift : r_shift;
    assign w_remFix  = r_remNeg ? -r_rem   : r_rem;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; start is only looked at while idle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_divByZero) begin
                        w_nextState = S_FIN;
                    end else if (w_isDiv) begin
                        w_nextState = S_DIV;
                    end else begin
                        w_nextState = S_MUL;
                    end
                end
            end
            S_MUL:   if (w_mulLast) w_nextState = S_FIX;
            S_DIV:   if (w_divLast) w_nextState = S_FIX;
            S_FIX:   w_nextState = S_FIN;
            S_FIN:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Outputs decoded from the state
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_divZero = 1'b0;
        case (r_state)
            S_MUL, S_DIV, S_FIX: w_busy = 1'b1;
            S_FIN: begin
                w_done    = 1'b1;
                w_divZero = r_zero;
            end
            default: ;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result write.
    // A divide by zero skips FIX, so hi/lo keep their previous contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_shift  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_isDiv  <= 1'b0;
            r_resNeg <= 1'b0;
            r_remNeg <= 1'b0;
            r_zero   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, (w_isDiv ? w_absB : w_absA)};
                        r_shift  <= w_isDiv ? w_absA : w_absB;
                        r_acc    <= '0;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_isDiv  <= w_isDiv;
                        r_resNeg <= w_aNeg ^ w_bNeg;
                        r_remNeg <= w_aNeg;
                        r_zero   <= w_divByZero;
                    end
                end
                S_MUL: begin
                    if (r_shift[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_shift <= r_shift >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    if (w_ge) begin
                        r_rem <= WIDTH'(w_partial - {1'b0, r_mcand[WIDTH-1:0]});
                    end else begin
                        r_rem <= w_partial[WIDTH-1:0];
                    end
                    r_shift <= {r_shift[WIDTH-2:0], w_ge};
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_isDiv) begin
                        r_hi <= w_remFix;
                        r_lo <= w_quotFix;
                    end else begin
                        r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.div_zero = w_divZero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit (WIDTH=32). Each request pushes its expected
// hi/lo/div_zero/latency into a queue; a monitor on the falling edge pops and
// compares whenever done is seen, and also checks that done is one cycle wide.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        int           startCycle;
    } exp_t;

    exp_t sbQueue[$];

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycleCount  = 0;
    logic prevDone    = 1'b0;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected multiply latency for a given multiplier magnitude
    function automatic int mulLat(input logic [W-1:0] bmag);
`ifdef MULDIV_EARLY_OUT_EN
        int n = 1;
        for (int i = 0; i < W; i++) begin
            if (bmag[i]) n = i + 1;
        end
        return n + 2;
`else
        return W + 2;
`endif
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (prevDone) checkOutput("done_single_pulse", {63'd0, bus.done}, 64'd0);
            if (bus.div_zero) checkOutput("div_zero_with_done", {63'd0, bus.done}, 64'd1);
            if (bus.done) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_done", {63'd0, bus.done}, 64'd0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
                    checkOutput({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
                    checkOutput({e.name, "_div_zero"}, {63'd0, bus.div_zero}, {63'd0, e.dz});
                    checkOutput({e.name, "_latency"}, 64'(cycleCount - e.startCycle), 64'(e.lat));
                end
            end
        end
        prevDone = bus.done && !reset;
    end

    // Wait (bounded) for done, counting cycles where busy is not as expected
    task automatic waitDone(input string name, input logic expBusy);
        int busyErr = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy !== expBusy) busyErr++;
        end
        checkOutput({name, "_done_seen"}, {63'd0, seen}, 64'd1);
        checkOutput({name, "_busy_until_done"}, 64'(busyErr), 64'd0);
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                                 input logic expDz, input int expLat);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.name       = name;
        e.hi         = expHi;
        e.lo         = expLo;
        e.dz         = expDz;
        e.lat        = expLat;
        e.startCycle = cycleCount;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(name, !expDz);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.done}, 64'd0);
        checkOutput("reset_div_zero", {63'd0, bus.div_zero}, 64'd0);
        checkOutput("reset_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, bus.lo}, 64'd0);

        // Signed and unsigned multiply
        applyStimulus("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5,
                      32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, mulLat(32'd5));
        applyStimulus("mult_neg1xneg1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'h0000_0000, 32'h0000_0001, 1'b0, mulLat(32'd1));
        applyStimulus("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFE, 32'h0000_0001, 1'b0, mulLat(32'hFFFF_FFFF));

        // Signed divide followed immediately by unsigned divide
        applyStimulus("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 2);
        applyStimulus("divu_7by2", OP_DIVU, 32'd7, 32'd2,
                      32'd1, 32'd3, 1'b0, W + 2);
        applyStimulus("div_7byneg2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
                      32'd1, 32'hFFFF_FFFD, 1'b0, W + 2);

        // Divide by zero leaves hi/lo untouched
        applyStimulus("multu_2x3", OP_MULTU, 32'd2, 32'd3,
                      32'd0, 32'd6, 1'b0, mulLat(32'd3));
        applyStimulus("div_by_zero", OP_DIV, 32'd9, 32'd0,
                      32'd0, 32'd6, 1'b1, 1);

        // Most negative / -1 wraps
        applyStimulus("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'd0, 32'h8000_0000, 1'b0, W + 2);

        // Start ignored while busy, then reset aborts the operation
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'h1234;
        bus.b     = 32'h10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd5;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("abort_busy_mid_op", {63'd0, bus.busy}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort_done", {63'd0, bus.done}, 64'd0);
        checkOutput("abort_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("abort_lo", {32'd0, bus.lo}, 64'd0);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Fresh operation after reset
        applyStimulus("multu_after_reset", OP_MULTU, 32'h1234, 32'h10,
                      32'd0, 32'h0001_2340, 1'b0, mulLat(32'h10));

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sbQueue.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
